// File: rtl/button_pio_if.sv
// Register-bus bundle for the button PIO: address/strobe/data from the host,
// registered read data and the level interrupt back from the peripheral.
interface button_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

// File: rtl/button_pio.sv
// Debounced button/sensor input port: per-bit 2-flop synchronizer, debounce counter,
// configurable rise/fall edge capture with write-one-to-clear and masked level irq.
module button_pio #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             reset,
  button_pio_if.slave      bus,
  input  logic [WIDTH-1:0] in_port
);

  localparam int CNT_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_RISE = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_CAP  = 3'd3;
  localparam logic [2:0] ADDR_FALL = 3'd4;
  localparam logic [2:0] ADDR_RAW  = 3'd5;

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [WIDTH-1:0] stable_r;
  logic [WIDTH-1:0] stable_nxt_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] rise_en_r;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_capture_r;
  logic [WIDTH-1:0] fall_en_r;
  logic [WIDTH-1:0] cap_set_s;
  logic [WIDTH-1:0] cap_clr_s;
  logic [WIDTH-1:0] cap_nxt_s;
  logic [WIDTH-1:0] wdata_s;
  logic [31:0]      rd_sel_s;
  logic [31:0]      readdata_r;
  logic             we_s;
  logic             wdata_unused_s;

  assign we_s           = bus.chipselect & ~bus.write_n;
  assign wdata_s        = bus.writedata[WIDTH-1:0];
  assign wdata_unused_s = ^bus.writedata;

  // Two-flop synchronizer for the asynchronous channel inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= {WIDTH{1'b0}};
      s2_r <= {WIDTH{1'b0}};
    end else begin
      s1_r <= in_port;
      s2_r <= s1_r;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      assign stable_nxt_s = s2_r;
    end else begin : g_debounce
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] cnt_r;
        logic             diff_s;
        logic             hit_s;

        assign diff_s          = s2_r[i] ^ stable_r[i];
        assign hit_s           = diff_s && (cnt_r == CNT_LAST);
        assign stable_nxt_s[i] = hit_s ? s2_r[i] : stable_r[i];

        // Count consecutive disagreeing cycles; the count never passes DEBOUNCE-1.
        always_ff @(posedge clk) begin
          if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (!diff_s || hit_s) begin
            cnt_r <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  // Debounced stable value.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_r <= {WIDTH{1'b0}};
    end else begin
      stable_r <= stable_nxt_s;
    end
  end

  assign rise_s = stable_nxt_s & ~stable_r;
  assign fall_s = ~stable_nxt_s & stable_r;

  // Edge capture next state; a new event on the same edge as a clear survives.
  always_comb begin
    cap_clr_s = {WIDTH{1'b0}};
    if (we_s && (bus.address == ADDR_CAP)) begin
      cap_clr_s = wdata_s;
    end else begin
      cap_clr_s = {WIDTH{1'b0}};
    end
    cap_set_s = (rise_s & rise_en_r) | (fall_s & fall_en_r);
    cap_nxt_s = (edge_capture_r & ~cap_clr_s) | cap_set_s;
  end

  // Control registers and edge capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_en_r      <= {WIDTH{1'b0}};
      irq_mask_r     <= {WIDTH{1'b0}};
      edge_capture_r <= {WIDTH{1'b0}};
      fall_en_r      <= {WIDTH{1'b1}};
    end else begin
      edge_capture_r <= cap_nxt_s;
      if (we_s) begin
        case (bus.address)
          ADDR_RISE: rise_en_r  <= wdata_s;
          ADDR_MASK: irq_mask_r <= wdata_s;
          ADDR_FALL: fall_en_r  <= wdata_s;
          default:   ;
        endcase
      end
    end
  end

  // Read select; unused upper bits and reserved addresses read as zero.
  always_comb begin
    rd_sel_s = 32'd0;
    case (bus.address)
      ADDR_DATA: rd_sel_s[WIDTH-1:0] = stable_r;
      ADDR_RISE: rd_sel_s[WIDTH-1:0] = rise_en_r;
      ADDR_MASK: rd_sel_s[WIDTH-1:0] = irq_mask_r;
      ADDR_CAP:  rd_sel_s[WIDTH-1:0] = edge_capture_r;
      ADDR_FALL: rd_sel_s[WIDTH-1:0] = fall_en_r;
      ADDR_RAW:  rd_sel_s[WIDTH-1:0] = s2_r;
      default:   rd_sel_s = 32'd0;
    endcase
  end

  // Registered read data, one cycle behind the address.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r <= 32'd0;
    end else begin
      readdata_r <= rd_sel_s;
    end
  end

  assign bus.readdata = readdata_r;
  assign bus.irq      = |(edge_capture_r & irq_mask_r);

endmodule
